// File: rtl/grf_scoreboard_if.sv
// Issue/retire/flush handshake between decode, writeback and the register scoreboard.
interface grf_scoreboard_if #(
  parameter int MAX_INFLIGHT = 4
);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  logic          iss_valid;
  logic [4:0]    iss_rs;
  logic [4:0]    iss_rt;
  logic          iss_use_rs;
  logic          iss_use_rt;
  logic [4:0]    iss_rd;
  logic          ret_valid;
  logic [4:0]    ret_rd;
  logic          flush;
  logic          stall;
  logic          iss_ack;
  logic [31:0]   busy_vec;
  logic [IW-1:0] inflight;
  logic          err;

  modport master (
    output iss_valid, iss_rs, iss_rt, iss_use_rs, iss_use_rt, iss_rd,
    output ret_valid, ret_rd, flush,
    input  stall, iss_ack, busy_vec, inflight, err
  );

  modport slave (
    input  iss_valid, iss_rs, iss_rt, iss_use_rs, iss_use_rt, iss_rd,
    input  ret_valid, ret_rd, flush,
    output stall, iss_ack, busy_vec, inflight, err
  );
endinterface

// File: rtl/grf_scoreboard.sv
// Register-dependency scoreboard: per-register pending-write counters gate decode on RAW,
// WAW-saturation and total in-flight capacity; the final retire releases readers via RF bypass.
module grf_scoreboard #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input logic             clk,
  input logic             reset,
  grf_scoreboard_if.slave bus
);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [IW-1:0]    INF_MAX = IW'(MAX_INFLIGHT);

  logic [CNT_W-1:0] w_cnt [32];
  logic [IW-1:0]    r_inflight;
  logic             r_err;
  logic [31:0]      w_busy;
  logic             w_raw_rs, w_raw_rt, w_waw, w_cap, w_stall, w_ack;
  logic             w_inc, w_dec, w_bad;

  // A source waiting only on a write that retires this cycle is served by the RF bypass.
  assign w_raw_rs = bus.iss_use_rs && (bus.iss_rs != 5'd0) && (w_cnt[bus.iss_rs] != '0) &&
                    !(bus.ret_valid && (bus.ret_rd == bus.iss_rs) && (w_cnt[bus.iss_rs] == CNT_ONE));
  assign w_raw_rt = bus.iss_use_rt && (bus.iss_rt != 5'd0) && (w_cnt[bus.iss_rt] != '0) &&
                    !(bus.ret_valid && (bus.ret_rd == bus.iss_rt) && (w_cnt[bus.iss_rt] == CNT_ONE));

  assign w_dec   = bus.ret_valid && (bus.ret_rd != 5'd0) && (w_cnt[bus.ret_rd] != '0);
  assign w_bad   = bus.ret_valid && (bus.ret_rd != 5'd0) && (w_cnt[bus.ret_rd] == '0);
  assign w_waw   = (bus.iss_rd != 5'd0) && (w_cnt[bus.iss_rd] == CNT_MAX);
  assign w_cap   = (bus.iss_rd != 5'd0) && (r_inflight == INF_MAX) && !w_dec;
  assign w_stall = bus.iss_valid && !bus.flush && (w_raw_rs || w_raw_rt || w_waw || w_cap);
  assign w_ack   = bus.iss_valid && !w_stall;
  assign w_inc   = w_ack && (bus.iss_rd != 5'd0);

  assign w_cnt[0] = '0;

  for (genvar g = 1; g < 32; g++) begin : g_reg
    logic [CNT_W-1:0] r_c;
    logic             w_up, w_dn;
    assign w_up     = w_inc && (bus.iss_rd == 5'(g));
    assign w_dn     = w_dec && (bus.ret_rd == 5'(g));
    assign w_cnt[g] = r_c;

    // Issue and retire on the same register cancel out.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)           r_c <= '0;
      else if (bus.flush)  r_c <= '0;
      else if (w_up && !w_dn) r_c <= r_c + CNT_ONE;
      else if (w_dn && !w_up) r_c <= r_c - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      if (bus.flush)           r_inflight <= '0;
      else if (w_inc && !w_dec) r_inflight <= r_inflight + IW'(1);
      else if (w_dec && !w_inc) r_inflight <= r_inflight - IW'(1);
      if (w_bad) r_err <= 1'b1;
    end
  end

  always_comb begin
    w_busy = '0;
    for (int r = 1; r < 32; r++) w_busy[r] = (w_cnt[r] != '0);
  end

  assign bus.stall    = w_stall;
  assign bus.iss_ack  = w_ack;
  assign bus.busy_vec = w_busy;
  assign bus.inflight = r_inflight;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_grf_scoreboard.sv
// Directed scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_grf_scoreboard;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  bit   stim_done = 1'b0;

  typedef struct {
    string       name;
    logic        es;
    logic        ea;
    logic [31:0] eb;
    int          ei;
    logic        ee;
  } exp_t;
  exp_t q[$];

  grf_scoreboard_if #(.MAX_INFLIGHT(4)) bus ();

  grf_scoreboard #(.CNT_W(2), .MAX_INFLIGHT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s got=%h want=%h", n, f, act, exp);
    end
  endtask

  // One stimulus cycle: drive inputs just after the edge, queue what the DUT must show before the next edge.
  task automatic cyc(input string nm, input logic rst, input logic iv,
                     input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                     input logic [4:0] rd, input logic rv, input logic [4:0] rrd, input logic fl,
                     input logic es, input logic ea, input logic [31:0] eb, input int ei, input logic ee);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst;
    bus.iss_valid  = iv;
    bus.iss_rs     = rs;
    bus.iss_use_rs = urs;
    bus.iss_rt     = rt;
    bus.iss_use_rt = urt;
    bus.iss_rd     = rd;
    bus.ret_valid  = rv;
    bus.ret_rd     = rrd;
    bus.flush      = fl;
    e.name = nm; e.es = es; e.ea = ea; e.eb = eb; e.ei = ei; e.ee = ee;
    q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.name, "stall",    32'(bus.stall),    32'(e.es));
        chk(e.name, "iss_ack",  32'(bus.iss_ack),  32'(e.ea));
        chk(e.name, "busy_vec", bus.busy_vec,      e.eb);
        chk(e.name, "inflight", 32'(bus.inflight), 32'(e.ei));
        chk(e.name, "err",      32'(bus.err),      32'(e.ee));
      end
    end
  end

  initial begin
    bus.iss_valid = 0; bus.iss_rs = 0; bus.iss_use_rs = 0; bus.iss_rt = 0; bus.iss_use_rt = 0;
    bus.iss_rd = 0; bus.ret_valid = 0; bus.ret_rd = 0; bus.flush = 0;
    //   name      rst iv rs urs rt urt rd rv rrd fl   stall ack busy          inf err
    cyc("rst",      1, 0, 0, 0, 0, 0, 0, 0, 0,  0,   0, 0, 32'h0,        0, 0);
    cyc("a_rd0ret", 0, 0, 0, 0, 0, 0, 0, 1, 0,  0,   0, 0, 32'h0,        0, 0);
    cyc("a_iss8",   0, 1, 0, 0, 0, 0, 8, 0, 0,  0,   0, 1, 32'h0,        0, 0);
    cyc("a_raw8",   0, 1, 8, 1, 0, 0, 0, 0, 0,  0,   1, 0, 32'h100,      1, 0);
    cyc("a_byp8",   0, 1, 8, 1, 0, 0, 0, 1, 8,  0,   0, 1, 32'h100,      1, 0);
    cyc("a_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0,   0, 0, 32'h0,        0, 0);
    cyc("b_iss5a",  0, 1, 0, 0, 0, 0, 5, 0, 0,  0,   0, 1, 32'h0,        0, 0);
    cyc("b_iss5b",  0, 1, 0, 0, 0, 0, 5, 0, 0,  0,   0, 1, 32'h20,       1, 0);
    cyc("b_iss5c",  0, 1, 0, 0, 0, 0, 5, 0, 0,  0,   0, 1, 32'h20,       2, 0);
    cyc("b_waw",    0, 1, 0, 0, 0, 0, 5, 0, 0,  0,   1, 0, 32'h20,       3, 0);
    cyc("b_wawret", 0, 1, 0, 0, 0, 0, 5, 1, 5,  0,   1, 0, 32'h20,       3, 0);
    cyc("b_iss5d",  0, 1, 0, 0, 0, 0, 5, 0, 0,  0,   0, 1, 32'h20,       2, 0);
    cyc("b_raw3",   0, 1, 5, 1, 0, 0, 0, 1, 5,  0,   1, 0, 32'h20,       3, 0);
    cyc("b_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0,  0,   0, 0, 32'h0,        0, 0);
    cyc("c_iss1",   0, 1, 0, 0, 0, 0, 1, 0, 0,  0,   0, 1, 32'h0,        0, 0);
    cyc("c_iss2",   0, 1, 0, 0, 0, 0, 2, 0, 0,  0,   0, 1, 32'h2,        1, 0);
    cyc("c_iss3",   0, 1, 0, 0, 0, 0, 3, 0, 0,  0,   0, 1, 32'h6,        2, 0);
    cyc("c_iss4",   0, 1, 0, 0, 0, 0, 4, 0, 0,  0,   0, 1, 32'he,        3, 0);
    cyc("c_full",   0, 1, 0, 0, 0, 0, 6, 0, 0,  0,   1, 0, 32'h1e,       4, 0);
    cyc("c_fullrt", 0, 1, 0, 0, 0, 0, 6, 1, 1,  0,   0, 1, 32'h1e,       4, 0);
    cyc("c_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0,   0, 0, 32'h5c,       4, 0);
    cyc("c_rawrt",  0, 1, 0, 0, 3, 1, 0, 0, 0,  0,   1, 0, 32'h5c,       4, 0);
    cyc("c_nouse",  0, 1, 3, 0, 3, 0, 0, 0, 0,  0,   0, 1, 32'h5c,       4, 0);
    cyc("c_ret6",   0, 0, 0, 0, 0, 0, 0, 1, 6,  0,   0, 0, 32'h5c,       4, 0);
    cyc("d_flush",  0, 1, 2, 1, 0, 0, 9, 0, 0,  1,   0, 1, 32'h1c,       3, 0);
    cyc("d_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0,   0, 0, 32'h0,        0, 0);
    cyc("e_badret", 0, 0, 0, 0, 0, 0, 0, 1, 12, 0,   0, 0, 32'h0,        0, 0);
    cyc("e_r0",     0, 1, 0, 1, 0, 1, 0, 0, 0,  0,   0, 1, 32'h0,        0, 1);
    cyc("e_iss7",   0, 1, 0, 0, 0, 0, 7, 0, 0,  0,   0, 1, 32'h0,        0, 1);
    cyc("e_ret7",   0, 0, 0, 0, 0, 0, 0, 1, 7,  0,   0, 0, 32'h80,       1, 1);
    cyc("e_idle",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0,   0, 0, 32'h0,        0, 1);
    cyc("e_flush",  0, 0, 0, 0, 0, 0, 0, 0, 0,  1,   0, 0, 32'h0,        0, 1);
    cyc("e_iss7b",  0, 1, 0, 0, 0, 0, 7, 0, 0,  0,   0, 1, 32'h0,        0, 1);
    cyc("e_arst",   1, 0, 0, 0, 0, 0, 0, 0, 0,  0,   0, 0, 32'h0,        0, 0);
    cyc("e_post",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0,   0, 0, 32'h0,        0, 0);
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    wait (stim_done);
    while (q.size() > 0 && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout reached without summary");
    $fatal(1);
  end
endmodule
